// File: rtl/ad_bus_demux.sv
// ad_bus_demux: receiving end of the multiplexed address/data link.
// An address phase on `ale` loads the beat address. Each `ds` data phase
// then emits one adr/dat transaction on a valid/ready output, and the
// address auto-increments for the next beat.
// Optional feature: define AD_PARITY_EN to add the `ad_par` port and
// even-parity checking of every strobe.
//
// Output handshake: a transaction transfers on a rising edge where vld
// and rdy are both high. Once vld rises, vld/adr/dat stay frozen until
// that edge. rdy may be high or low at any time without affecting vld.
// The sender is told it may issue its next strobe by a one-cycle `ack`
// pulse.
module ad_bus_demux #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] ad,
    input  logic         ale,
    input  logic         ds,
`ifdef AD_PARITY_EN
    input  logic         ad_par,
`endif
    output logic         ack,
    output logic [W-1:0] adr,
    output logic [W-1:0] dat,
    output logic         vld,
    input  logic         rdy,
    output logic         err,
    output logic [7:0]   err_cnt,
    output logic [1:0]   dbg_state
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HAVE_ADR = 2'd1,
        HOLD     = 2'd2
    } state_t;

    state_t         state, state_n;
    logic [W-1:0]   adr_reg, adr_reg_n;
    logic [W-1:0]   adr_n, dat_n;
    logic           vld_n, ack_n, err_n;
    logic           par_bad;

    assign dbg_state = state;

    // Parity failure on a strobe cycle: the whole strobe is rejected
`ifdef AD_PARITY_EN
    assign par_bad = (ale | ds) & (^{ad, ad_par});
`else
    assign par_bad = 1'b0;
`endif

    // Next-state and next-output decode
    always_comb begin
        state_n   = state;
        adr_reg_n = adr_reg;
        adr_n     = adr;
        dat_n     = dat;
        vld_n     = vld;
        ack_n     = 1'b0;
        err_n     = 1'b0;

        // Both strobes at once: ale wins, ds is dropped and flagged
        if (ale && ds) begin
            err_n = 1'b1;
        end

        unique case (state)
            IDLE: begin
                if (!par_bad) begin
                    if (ale) begin
                        adr_reg_n = ad;
                        ack_n     = 1'b1;
                        state_n   = HAVE_ADR;
                    end else if (ds) begin
                        // Data without a preceding address
                        err_n = 1'b1;
                    end
                end
            end
            HAVE_ADR: begin
                if (!par_bad) begin
                    if (ale) begin
                        adr_reg_n = ad;
                        ack_n     = 1'b1;
                    end else if (ds) begin
                        adr_n     = adr_reg;
                        dat_n     = ad;
                        vld_n     = 1'b1;
                        adr_reg_n = adr_reg + {{(W-1){1'b0}}, 1'b1};
                        state_n   = HOLD;
                    end
                end
            end
            HOLD: begin
                // The pending beat completes independently of strobe traffic
                if (vld && rdy) begin
                    vld_n   = 1'b0;
                    ack_n   = 1'b1;
                    state_n = HAVE_ADR;
                end
                // The sender must wait for ack; any strobe here is dropped
                if (ale || ds) begin
                    err_n = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (par_bad) begin
            err_n = 1'b1;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            adr_reg <= '0;
            adr     <= '0;
            dat     <= '0;
            vld     <= 1'b0;
            ack     <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_n;
            adr_reg <= adr_reg_n;
            adr     <= adr_n;
            dat     <= dat_n;
            vld     <= vld_n;
            ack     <= ack_n;
            err     <= err_n;
        end
    end

    // Saturating count of error pulses, one per offending cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= 8'd0;
        end else if (err_n && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_ad_bus_demux.sv
// tb_ad_bus_demux: directed bench for ad_bus_demux. Expected transactions
// are queued when a ds beat is driven and compared when the output handshake
// completes. Signal-level expectations are checked with immediate assertions.
module tb_ad_bus_demux;

    localparam int W = 8;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HAVE = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] ad;
    logic         ale;
    logic         ds;
`ifdef AD_PARITY_EN
    logic         ad_par;
`endif
    logic         ack;
    logic [W-1:0] adr;
    logic [W-1:0] dat;
    logic         vld;
    logic         rdy;
    logic         err;
    logic [7:0]   err_cnt;
    logic [1:0]   dbg_state;

    int checks = 0;
    int errors = 0;
    int beats  = 0;
    logic [15:0] exp_q[$];

    // Clock and reset
    always #5 clk = ~clk;

    ad_bus_demux #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .ad        (ad),
        .ale       (ale),
        .ds        (ds),
`ifdef AD_PARITY_EN
        .ad_par    (ad_par),
`endif
        .ack       (ack),
        .adr       (adr),
        .dat       (dat),
        .vld       (vld),
        .rdy       (rdy),
        .err       (err),
        .err_cnt   (err_cnt),
        .dbg_state (dbg_state)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Put a value on the bus with correct parity
    task automatic drive_ad(input logic [W-1:0] v);
        ad = v;
`ifdef AD_PARITY_EN
        ad_par = ^v;
`endif
    endtask

    // Scoreboard: a beat transfers at the next edge when vld&rdy hold now
    always @(negedge clk) begin
        if (!rst && vld && rdy) begin
            beats++;
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL spurious_beat: observed adr %0h dat %0h expected none", adr, dat);
            end
            if (exp_q.size() != 0) begin
                check("beat", {adr, dat}, exp_q.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b1;
        ale = 1'b0;
        ds  = 1'b0;
        rdy = 1'b0;
        drive_ad(8'h00);

        // Reset values
        tick(); tick();
        check("rst_ack", 16'(ack), 16'd0);
        check("rst_vld", 16'(vld), 16'd0);
        check("rst_adr", 16'(adr), 16'd0);
        check("rst_dat", 16'(dat), 16'd0);
        check("rst_err", 16'(err), 16'd0);
        check("rst_err_cnt", 16'(err_cnt), 16'd0);
        check("rst_state", 16'(dbg_state), 16'(S_IDLE));
        rst = 1'b0;
        tick();

        // Single transaction
        rdy = 1'b1;
        drive_ad(8'h10); ale = 1'b1;
        tick(); ale = 1'b0;
        check("t1_ack", 16'(ack), 16'd1);
        check("t1_state", 16'(dbg_state), 16'(S_HAVE));
        tick();
        check("t1_ack_once", 16'(ack), 16'd0);
        drive_ad(8'hA5); ds = 1'b1; exp_q.push_back({8'h10, 8'hA5});
        tick(); ds = 1'b0;
        check("t1_vld", 16'(vld), 16'd1);
        check("t1_adr_dat", {adr, dat}, 16'h10A5);
        check("t1_no_ack", 16'(ack), 16'd0);
        tick();
        check("t1_hs_vld", 16'(vld), 16'd0);
        check("t1_hs_ack", 16'(ack), 16'd1);

        // Burst across the address wrap, back-to-back at full rate
        drive_ad(8'hFE); ale = 1'b1;
        tick(); ale = 1'b0;
        check("burst_ack", 16'(ack), 16'd1);
        for (int i = 0; i < 3; i++) begin
            drive_ad(8'(i + 1)); ds = 1'b1;
            exp_q.push_back({8'(8'hFE + i), 8'(i + 1)});
            tick(); ds = 1'b0;
            check("burst_vld", 16'(vld), 16'd1);
            tick();
            check("burst_ack_beat", 16'(ack), 16'd1);
        end

        // Backpressure with an illegal ds injected during HOLD
        rdy = 1'b0;
        drive_ad(8'h40); ale = 1'b1;
        tick(); ale = 1'b0;
        drive_ad(8'h77); ds = 1'b1; exp_q.push_back({8'h40, 8'h77});
        tick(); ds = 1'b0;
        check("bp_state", 16'(dbg_state), 16'(S_HOLD));
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                drive_ad(8'h99); ds = 1'b1;
            end
            tick(); ds = 1'b0;
            check("bp_vld", 16'(vld), 16'd1);
            check("bp_adr_dat", {adr, dat}, 16'h4077);
            check("bp_ack", 16'(ack), 16'd0);
            check("bp_err", 16'(err), (i == 1) ? 16'd1 : 16'd0);
        end
        check("bp_err_cnt", 16'(err_cnt), 16'd1);
        rdy = 1'b1;
        tick();
        check("bp_hs_vld", 16'(vld), 16'd0);
        check("bp_hs_ack", 16'(ack), 16'd1);

        // ds in IDLE, then ale+ds together in HAVE_ADR
        rst = 1'b1;
        tick(); rst = 1'b0;
        check("v_state", 16'(dbg_state), 16'(S_IDLE));
        drive_ad(8'h33); ds = 1'b1;
        tick(); ds = 1'b0;
        check("v_idle_err", 16'(err), 16'd1);
        check("v_idle_state", 16'(dbg_state), 16'(S_IDLE));
        check("v_idle_cnt", 16'(err_cnt), 16'd1);
        tick();
        check("v_err_once", 16'(err), 16'd0);
        drive_ad(8'h20); ale = 1'b1;
        tick(); ale = 1'b0;
        drive_ad(8'h50); ale = 1'b1; ds = 1'b1;
        tick(); ale = 1'b0; ds = 1'b0;
        check("v_both_ack", 16'(ack), 16'd1);
        check("v_both_err", 16'(err), 16'd1);
        check("v_both_vld", 16'(vld), 16'd0);
        check("v_both_cnt", 16'(err_cnt), 16'd2);
        drive_ad(8'h11); ds = 1'b1; exp_q.push_back({8'h50, 8'h11});
        tick(); ds = 1'b0;
        check("v_both_adr", 16'(adr), 16'h0050);
        tick();

        // Error counter saturation
        rst = 1'b1;
        tick(); rst = 1'b0;
        ds = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (i == 254) check("sat_254", 16'(err_cnt), 16'd254);
            if (i == 255) check("sat_255", 16'(err_cnt), 16'd255);
        end
        ds = 1'b0;
        check("sat_300", 16'(err_cnt), 16'd255);
        tick();
        check("sat_err_low", 16'(err), 16'd0);
        check("sat_hold", 16'(err_cnt), 16'd255);

        // Reset while a beat is pending drops it
        rdy = 1'b0;
        drive_ad(8'h60); ale = 1'b1;
        tick(); ale = 1'b0;
        drive_ad(8'h61); ds = 1'b1;
        tick(); ds = 1'b0;
        check("rh_vld", 16'(vld), 16'd1);
        check("rh_state", 16'(dbg_state), 16'(S_HOLD));
        rst = 1'b1;
        tick(); rst = 1'b0;
        check("rh_vld_drop", 16'(vld), 16'd0);
        check("rh_cnt", 16'(err_cnt), 16'd0);
        check("rh_state_idle", 16'(dbg_state), 16'(S_IDLE));
        drive_ad(8'h62); ds = 1'b1;
        tick(); ds = 1'b0;
        check("rh_ds_err", 16'(err), 16'd1);
        check("rh_ds_vld", 16'(vld), 16'd0);
        tick();

`ifdef AD_PARITY_EN
        // Parity rejection and retry
        ad = 8'h03; ad_par = 1'b1; ale = 1'b1;
        tick(); ale = 1'b0;
        check("par_err", 16'(err), 16'd1);
        check("par_no_ack", 16'(ack), 16'd0);
        check("par_state", 16'(dbg_state), 16'(S_IDLE));
        ad = 8'h03; ad_par = 1'b0; ale = 1'b1;
        tick(); ale = 1'b0;
        check("par_retry_ack", 16'(ack), 16'd1);
        check("par_retry_err", 16'(err), 16'd0);
        rdy = 1'b1;
        drive_ad(8'h00); ds = 1'b1; exp_q.push_back({8'h03, 8'h00});
        tick(); ds = 1'b0;
        check("par_adr", 16'(adr), 16'h0003);
        tick();
`endif

        // Every queued beat must have been delivered, nothing extra
        tick(); tick();
        check("queue_empty", 16'(exp_q.size()), 16'd0);
`ifdef AD_PARITY_EN
        check("beat_count", 16'(beats), 16'd7);
`else
        check("beat_count", 16'(beats), 16'd6);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ad_bus_demux.md
# ad_bus_demux

Receiving end of the multiplexed address/data link driven by the lab's address/data switch. It samples a shared `ad` bus qualified by an address strobe (`ale`) and a data strobe (`ds`), and reassembles separate address and data words. Each data beat is presented as an `adr`/`dat` transaction on a valid/ready output. A burst is one address phase followed by any number of data beats, with the address auto-incrementing per beat.

## Interface
- `W`, 8, width of `ad`, `adr`, `dat`
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `ad`  in  W  multiplexed address/data bus
- `ale`  in  1  address strobe, one-cycle pulse
- `ds`  in  1  data strobe, one-cycle pulse
- `ad_par`  in  1  even-parity bit over `ad`; port exists only with `AD_PARITY_EN`
- `ack`  out  1  one-cycle pulse: strobe fully accepted, sender may issue next strobe
- `adr`  out  W  transaction address
- `dat`  out  W  transaction data
- `vld`  out  1  transaction valid
- `rdy`  in  1  downstream ready
- `err`  out  1  one-cycle pulse on protocol or parity violation
- `err_cnt`  out  8  saturating count of `err` pulses

## Operation
- Internal state: `adr_reg[W]` holds the next beat address. FSM states are IDLE, HAVE_ADR and HOLD.
- IDLE:
  - `ale`=1: `adr_reg<=ad`, `ack` pulse, go to HAVE_ADR.
  - `ds`=1 with `ale`=0: `err` pulse, strobe dropped, state unchanged.
- HAVE_ADR:
  - `ale`=1: `adr_reg<=ad` (new burst), `ack` pulse.
  - `ds`=1: `adr<=adr_reg`, `dat<=ad`, `vld<=1`, `adr_reg<=adr_reg+1` modulo 2^W, go to HOLD. No `ack` yet.
- HOLD:
  - `vld`, `adr` and `dat` are held stable until `rdy`=1 is sampled.
  - On `vld&rdy`: `vld<=0`, `ack` pulse, go to HAVE_ADR.
  - Any `ale` or `ds` while in HOLD: `err` pulse, strobe dropped. This includes the cycle in which `rdy` completes the handshake.
- `ale` and `ds` high in the same cycle, in any state: `ale` is processed per the current state, `ds` is ignored, and `err` pulses.
- `err_cnt` increments by one per `err` pulse and saturates at 255. Multiple violations in one cycle count once.
- `adr_reg` wrap: with `W`=8, base 0xFF gives beat addresses 0xFF, 0x00, 0x01, …

## Timing
- Reset values: `ack`=0, `adr`=0, `dat`=0, `vld`=0, `err`=0, `err_cnt`=0, `adr_reg`=0, state IDLE.
- Reset asserted during HOLD drops the pending beat. `vld` is low in the cycle after the reset edge.
- All inputs are sampled on `clk` rising edges. All outputs are registered.
- `ale` accepted at edge N: `ack`=1 during cycle N+1 only.
- `ds` accepted at edge N: `vld`, `adr`, `dat` valid from cycle N+1.
- Handshake at edge M: `vld`=0 and `ack`=1 during cycle M+1. A `ds` at edge M+1 is accepted.
- `err` is high for the single cycle following the offending edge.
- With `rdy` tied high, peak throughput is one beat per 2 cycles.

## Configuration
- `AD_PARITY_EN` defined:
  - `ad_par` port present.
  - On any strobe, `^{ad,ad_par}` must be 0.
  - On mismatch: `err` pulse, no `ack`, no register or state change.
  - Parity is checked before the rules in Operation. A parity failure with both strobes high counts as one error.
- `AD_PARITY_EN` undefined: `ad_par` port absent, no parity check.

## Test plan
- Reset, then `ale` with `ad`=0x10, then `ds` with `ad`=0xA5, `rdy`=1 → `ack` one cycle after the `ale` edge. `vld` one cycle after the `ds` edge with `adr`=0x10, `dat`=0xA5. `ack` in the cycle after the handshake.
- Burst: `ale` with 0xFE, then 3 `ds` beats 0x01/0x02/0x03 → transactions at `adr` 0xFE, 0xFF, 0x00 (wrap), data in order.
- Backpressure: `rdy`=0 for 5 cycles after `vld`, with a `ds` injected during HOLD → `vld`/`adr`/`dat` stable throughout. `err` pulses once and `err_cnt`=1. The injected beat never appears. `ack` only after `rdy`=1.
- `ds` in IDLE and simultaneous `ale`+`ds` in HAVE_ADR → each gives an `err` pulse. The `ale` address is captured and no transaction is emitted. After 300 forced violations, `err_cnt` reads 255.
- Synchronous reset asserted while in HOLD with `rdy`=0 → next cycle: `vld`=0, `err_cnt`=0, state IDLE. A subsequent `ds` without `ale` gives an `err` pulse.
- With `AD_PARITY_EN`: `ale` with `ad`=0x03 and `ad_par`=1 → `err` pulse, no `ack`. Retry with `ad_par`=0 → `ack`, address 0x03 captured.
